ir_servo_sequencer: RTL and testbench
=====================================

# ir_servo_sequencer

Servo sequencer that sits on the far side of the line follower's IR-stop handshake. It responds to `EnableIRModule` by driving two hobby servos (arm and claw) through a fixed pick-up sequence: open, lower, close, raise. It then raises `IRModuleDone` and holds it until the controller clears it with `ResetIRModule`. It generates both 50 Hz servo PWM signals itself from the system clock.

## Interface
Parameters:
- `PERIOD_CYC`, default 2_000_000: PWM frame length in clocks (20 ms at 100 MHz).
- `POS_MIN`, default 100_000: 1 ms pulse width. Arm up, claw closed.
- `POS_MAX`, default 200_000: 2 ms pulse width. Arm down, claw open.
- `DWELL_FRAMES`, default 25: frames spent in each sequence step (0.5 s).

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `EnableIRModule` input 1: start request from the line follower.
- `ResetIRModule` input 1: synchronous soft clear. Returns the block to IDLE and drops Done.
- `IRModuleDone` output 1, registered: sequence complete. Held until `ResetIRModule`.
- `ServoArm` output 1, registered: arm servo PWM.
- `ServoClaw` output 1, registered: claw servo PWM.
- `Step` output 3, registered: current state encoding, for debug LEDs.

## Operation
- Frame counter `fc` counts 0..PERIOD_CYC-1 and wraps. It is free-running and is not affected by enable.
- A frame boundary is the cycle where `fc == PERIOD_CYC-1`.
- Servo outputs are defined as follows:
  - `ServoArm = (fc < armW)`
  - `ServoClaw = (fc < clawW)`
  - Both are registered, so each output lags `fc` by one cycle.
- `armW` and `clawW` are loaded only at frame boundaries. A pulse is never truncated or stretched mid-frame.
- States and their `Step` encodings:
  - IDLE = 0: arm POS_MIN, claw POS_MIN.
  - OPEN = 1: claw POS_MAX.
  - LOWER = 2: arm POS_MAX.
  - CLOSE = 3: claw POS_MIN.
  - RAISE = 4: arm POS_MIN.
  - DONE = 5: arm POS_MIN, claw POS_MIN.
- Each active step holds the positions of the previous step and changes only the servo named for that step.
- IDLE → OPEN happens at the first frame boundary where `EnableIRModule` is 1.
- Each active step lasts exactly DWELL_FRAMES frames. A dwell counter increments at frame boundaries, then clears and advances the state.
- RAISE → DONE happens at the frame boundary that ends the last RAISE frame. `IRModuleDone` goes 1 on the cycle after that boundary.
- In DONE:
  - Servos hold their rest positions.
  - `IRModuleDone` stays 1 regardless of `EnableIRModule`.
  - A re-asserted enable without a reset does not restart the sequence.
- `ResetIRModule` = 1:
  - Next cycle: state IDLE, dwell counter 0, `IRModuleDone` 0.
  - Pending width registers are set to POS_MIN and take effect at the next frame boundary.
  - `fc` is untouched.
  - It has priority over `EnableIRModule` in the same cycle.
- Dropping `EnableIRModule` mid-sequence does not abort; the sequence runs to DONE. Only `ResetIRModule` or `rst` aborts.
- Counter widths:
  - `fc` uses `$clog2(PERIOD_CYC)` bits.
  - The dwell counter uses `$clog2(DWELL_FRAMES+1)` bits.
  - POS_MAX < PERIOD_CYC is required, so no overflow is possible.

## Timing
- Reset values while `rst` is high:
  - `fc` = 0, state IDLE, dwell = 0.
  - `armW` = `clawW` = POS_MIN.
  - `IRModuleDone` = 0, `ServoArm` = 0, `ServoClaw` = 0, `Step` = 0.
- After `rst` falls, the first output pulse starts one cycle after `fc` first reads 0.
- Start latency: 1 to PERIOD_CYC cycles, from enable to the first OPEN frame.
- Sequence length: 4·DWELL_FRAMES·PERIOD_CYC cycles, from the first OPEN frame start to `IRModuleDone` rising (plus the 1-cycle register lag).
- Handshake expected from the controller:
  - It deasserts enable and pulses `ResetIRModule` for ≥1 cycle in response to Done.
  - Done falls 1 cycle after reset is sampled.
- Reset mid-operation, whether `rst` or `ResetIRModule`, leaves no residual state. A fresh enable replays the full sequence.

## Test plan
All scenarios use PERIOD_CYC=100, POS_MIN=10, POS_MAX=20, DWELL_FRAMES=2.
- Reset, then idle for 300 cycles → both servos high 10 cycles per 100-cycle frame, `Step`=0, Done=0.
- Enable raised at `fc`=40 and held → OPEN frames start at the next wrap. `ServoClaw` width is 20 for 2 frames, then arm 20 for 2, claw 10 for 2, arm 10 for 2. `Step` reads 1,2,3,4. Done rises 800 cycles after OPEN starts.
- In DONE, drop enable, wait 500 cycles → Done stays 1. Pulse `ResetIRModule` for 1 cycle → Done 0 next cycle, `Step`=0. Re-enable → full 800-cycle replay.
- Assert `ResetIRModule` and `EnableIRModule` together during LOWER → state IDLE next cycle. The current arm pulse completes at width 20, then 10 from the next frame.
- Assert async `rst` mid-pulse at `fc`=5 during CLOSE → all outputs 0 immediately (no clock edge needed). After release, idle pulses are width 10 and Done=0.
- Drop enable after 1 frame of OPEN → the sequence still completes and Done rises at the same cycle as in scenario 2.

Source files
------------

// File: rtl/ir_servo_sequencer.sv
// Servo pick-up sequencer: on enable, walks arm/claw servos through open, lower,
// close, raise, then holds IRModuleDone until a soft clear. Generates both 50 Hz PWMs.
module ir_servo_sequencer #(
    parameter int unsigned PERIOD_CYC   = 2_000_000,
    parameter int unsigned POS_MIN      = 100_000,
    parameter int unsigned POS_MAX      = 200_000,
    parameter int unsigned DWELL_FRAMES = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EnableIRModule,
    input  logic       ResetIRModule,
    output logic       IRModuleDone,
    output logic       ServoArm,
    output logic       ServoClaw,
    output logic [2:0] Step
);

    localparam int unsigned FCW = $clog2(PERIOD_CYC);
    localparam int unsigned DWW = $clog2(DWELL_FRAMES + 1);

    localparam logic [FCW-1:0] FC_LAST = FCW'(PERIOD_CYC - 1);
    localparam logic [FCW-1:0] W_MIN   = FCW'(POS_MIN);
    localparam logic [FCW-1:0] W_MAX   = FCW'(POS_MAX);
    localparam logic [DWW-1:0] DW_LAST = DWW'(DWELL_FRAMES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_OPEN  = 3'd1;
    localparam logic [2:0] S_LOWER = 3'd2;
    localparam logic [2:0] S_CLOSE = 3'd3;
    localparam logic [2:0] S_RAISE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [FCW-1:0] r_fc;
    logic [2:0]     r_state;
    logic [DWW-1:0] r_dwell;
    logic [FCW-1:0] r_arm_w;
    logic [FCW-1:0] r_claw_w;
    logic           r_done;
    logic           r_arm;
    logic           r_claw;

    logic           w_fb;
    logic [2:0]     w_state_nxt;
    logic [DWW-1:0] w_dwell_nxt;
    logic [FCW-1:0] w_arm_nxt;
    logic [FCW-1:0] w_claw_nxt;

    assign w_fb = (r_fc == FC_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        if (ResetIRModule) begin
            w_state_nxt = S_IDLE;
            w_dwell_nxt = '0;
        end else if (w_fb) begin
            case (r_state)
                S_IDLE: if (EnableIRModule) w_state_nxt = S_OPEN;
                S_DONE: w_state_nxt = S_DONE;
                default: begin
                    // active steps are numbered consecutively, so advancing is +1
                    if (r_dwell == DW_LAST) begin
                        w_dwell_nxt = '0;
                        w_state_nxt = r_state + 3'd1;
                    end else begin
                        w_dwell_nxt = r_dwell + DWW'(1);
                    end
                end
            endcase
        end
    end

    // Pending widths follow the next state; they only reach the PWM at a frame boundary.
    always_comb begin
        w_arm_nxt  = W_MIN;
        w_claw_nxt = W_MIN;
        case (w_state_nxt)
            S_OPEN:  w_claw_nxt = W_MAX;
            S_LOWER: begin
                w_arm_nxt  = W_MAX;
                w_claw_nxt = W_MAX;
            end
            S_CLOSE: w_arm_nxt = W_MAX;
            default: begin
                w_arm_nxt  = W_MIN;
                w_claw_nxt = W_MIN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fc     <= '0;
            r_state  <= S_IDLE;
            r_dwell  <= '0;
            r_arm_w  <= W_MIN;
            r_claw_w <= W_MIN;
            r_done   <= 1'b0;
            r_arm    <= 1'b0;
            r_claw   <= 1'b0;
        end else begin
            r_fc    <= w_fb ? '0 : r_fc + FCW'(1);
            r_state <= w_state_nxt;
            r_dwell <= w_dwell_nxt;
            if (w_fb) begin
                r_arm_w  <= w_arm_nxt;
                r_claw_w <= w_claw_nxt;
            end
            r_done <= (w_state_nxt == S_DONE);
            r_arm  <= (r_fc < r_arm_w);
            r_claw <= (r_fc < r_claw_w);
        end
    end

    assign IRModuleDone = r_done;
    assign ServoArm     = r_arm;
    assign ServoClaw    = r_claw;
    assign Step         = r_state;

endmodule

// File: tb/tb_ir_servo_sequencer.sv
// Directed bench for ir_servo_sequencer with a short 100-cycle frame and 2-frame dwell.
module tb_ir_servo_sequencer;

    localparam int P = 100;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       en   = 1'b0;
    logic       srst = 1'b0;
    logic       done;
    logic       arm;
    logic       claw;
    logic [2:0] step;

    int cyc     = 0;
    int abs_cyc = 0;
    int passed  = 0;
    int fails   = 0;
    int total   = 0;
    int a0;
    int ca;
    int cc;

    ir_servo_sequencer #(
        .PERIOD_CYC  (P),
        .POS_MIN     (10),
        .POS_MAX     (20),
        .DWELL_FRAMES(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .EnableIRModule(en),
        .ResetIRModule (srst),
        .IRModuleDone  (done),
        .ServoArm      (arm),
        .ServoClaw     (claw),
        .Step          (step)
    );

    always #5 clk = ~clk;

    // cyc % P tracks the frame position the DUT should be at
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(posedge clk) abs_cyc <= abs_cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_fc(input int f);
        for (int i = 0; i < 2 * P && (cyc % P) != f; i++) @(negedge clk);
    endtask

    task automatic wait_step(input string tag, input int s);
        for (int i = 0; i < 1000 && step !== 3'(s); i++) @(negedge clk);
        chk(tag, step, s);
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        for (int i = 0; i < 1200 && done !== 1'b1; i++) @(negedge clk);
        chk(tag, abs_cyc, exp_cyc);
    endtask

    // Samples at frame positions 1..99,0 see the registered PWM for fc 0..99.
    task automatic frame(input string tag, input int ea, input int ec, input int es);
        int a;
        int c;
        logic [2:0] s;
        a = 0;
        c = 0;
        wait_fc(1);
        s = step;
        for (int i = 0; i < P; i++) begin
            if (i > 0) @(negedge clk);
            a += int'(arm);
            c += int'(claw);
        end
        chk({tag, "_arm"}, a, ea);
        chk({tag, "_claw"}, c, ec);
        chk({tag, "_step"}, s, es);
    endtask

    int exp_a [8] = '{10, 10, 20, 20, 20, 20, 10, 10};
    int exp_c [8] = '{20, 20, 20, 20, 10, 10, 10, 10};
    int exp_s [8] = '{1, 1, 2, 2, 3, 3, 4, 4};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_arm", arm, 0);
        chk("rst_claw", claw, 0);
        chk("rst_done", done, 0);
        chk("rst_step", step, 0);
        rst = 1'b0;

        for (int f = 0; f < 3; f++) frame("idle", 10, 10, 0);
        chk("idle_done", done, 0);

        // full sequence with enable held
        wait_fc(40);
        en = 1'b1;
        for (int f = 0; f < 8; f++) frame($sformatf("seq%0d", f), exp_a[f], exp_c[f], exp_s[f]);
        chk("seq_done", done, 1);
        chk("seq_done_step", step, 5);

        // DONE holds without enable, clears on soft reset, then replays
        en = 1'b0;
        repeat (500) @(negedge clk);
        chk("hold_done", done, 1);
        frame("done_rest", 10, 10, 5);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        chk("clr_done", done, 0);
        chk("clr_step", step, 0);
        wait_fc(40);
        en = 1'b1;
        a0 = abs_cyc;
        wait_done("replay_time", a0 + 860);
        en = 1'b0;
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        chk("clr2_done", done, 0);

        // soft reset together with enable during LOWER, mid arm pulse
        wait_fc(40);
        en = 1'b1;
        wait_step("reach_lower", 2);
        wait_fc(1);
        ca = 0;
        cc = 0;
        for (int i = 0; i < P; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 4) srst = 1'b1;
            if (i == 5) begin
                chk("lower_clr_step", step, 0);
                srst = 1'b0;
                en   = 1'b0;
            end
            ca += int'(arm);
            cc += int'(claw);
        end
        chk("lower_clr_arm", ca, 20);
        chk("lower_clr_claw", cc, 20);
        frame("post_clr", 10, 10, 0);
        chk("post_clr_done", done, 0);

        // async reset mid arm pulse during CLOSE
        en = 1'b1;
        wait_step("reach_close", 3);
        wait_fc(5);
        en = 1'b0;
        chk("close_arm_high", arm, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_arm", arm, 0);
        chk("async_claw", claw, 0);
        chk("async_done", done, 0);
        chk("async_step", step, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        frame("after_rst", 10, 10, 0);
        chk("after_rst_done", done, 0);

        // enable dropped after the first OPEN frame still completes on time
        wait_fc(40);
        en = 1'b1;
        a0 = abs_cyc;
        frame("s6_open", 10, 20, 1);
        en = 1'b0;
        wait_done("s6_done_time", a0 + 860);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
